// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program into instruction memory, then runs the core until halt.
// Optional trailing XOR checksum byte enabled with `define IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int IMEM_BYTES  = 1024,
  parameter int RUN_TIMEOUT = 65535,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             cpu_halt,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_reset,
  output logic             running,
  output logic             halted,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] run_cycles
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] LEN_HI = 3'd2;
  localparam logic [2:0] LOAD   = 3'd3;
  localparam logic [2:0] CHK    = 3'd4;
  localparam logic [2:0] RUN    = 3'd5;
  localparam logic [2:0] HALTED = 3'd6;
  localparam logic [2:0] ERROR  = 3'd7;

  localparam logic [16:0] MAXW = 17'(IMEM_BYTES / 4);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(RUN_TIMEOUT);

`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam logic [2:0] POST = CHK;
`else
  localparam logic [2:0] POST = RUN;
`endif

  logic [2:0]       state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [CNT_W-1:0] widx_q, widx_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [31:0]      asm_q, asm_d;
  logic [7:0]       csum_q, csum_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [1:0]       err_q, err_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             rdy_q, rdy_d;
  logic             crst_q, crst_d;
  logic             run_o_q, run_o_d;
  logic             hlt_q, hlt_d;
  logic             err_o_q, err_o_d;

  logic             acc;
  logic [15:0]      n_full;
  logic [CNT_W-1:0] widx_inc;
  logic [CNT_W-1:0] run_inc;
  logic [31:0]      word;

  assign acc      = in_valid && rdy_q;
  assign n_full   = {in_data, len_q[7:0]};
  assign widx_inc = widx_q + CNT_W'(1);
  assign run_inc  = (run_q == '1) ? run_q : run_q + CNT_W'(1);
  assign word     = {in_data, asm_q[31:8]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    csum_d  = csum_q;
    run_d   = run_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, HALTED, ERROR: begin
        if (start) begin
          state_d = LEN_LO;
          len_d   = '0;
          widx_d  = '0;
          bcnt_d  = '0;
          csum_d  = '0;
          run_d   = '0;
          err_d   = 2'b00;
        end
      end
      LEN_LO: begin
        if (acc) begin
          len_d[7:0] = in_data;
          csum_d     = csum_q ^ in_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (acc) begin
          len_d  = n_full;
          csum_d = csum_q ^ in_data;
          if ({1'b0, n_full} > MAXW) begin
            state_d = ERROR;
            err_d   = 2'b01;
          end else if (n_full == 16'd0) begin
            state_d = POST;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (acc) begin
          csum_d = csum_q ^ in_data;
          bcnt_d = bcnt_q + 2'd1;
          asm_d  = word;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = 32'(widx_q) << 2;
            wdata_d = word;
            widx_d  = widx_inc;
`ifdef IMEM_BOOT_CHECKSUM_EN
            if (widx_inc == CNT_W'(len_q)) state_d = CHK;
`endif
          end
        end else if (widx_q == CNT_W'(len_q)) begin
          // last word is being written this cycle; release core afterwards
          state_d = RUN;
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      CHK: begin
        if (acc) begin
          if (in_data == csum_q) begin
            state_d = RUN;
          end else begin
            state_d = ERROR;
            err_d   = 2'b10;
          end
        end
      end
`endif
      RUN: begin
        run_d = run_inc;
        if (cpu_halt) begin
          state_d = HALTED;
        end else if (run_inc == TMO) begin
          state_d = ERROR;
          err_d   = 2'b11;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy_d   = (state_d == LEN_LO) || (state_d == LEN_HI) ||
              (state_d == CHK) ||
              ((state_d == LOAD) && (widx_d != CNT_W'(len_d)));
    crst_d  = (state_d != RUN);
    run_o_d = (state_d == RUN);
    hlt_d   = (state_d == HALTED);
    err_o_d = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      csum_q  <= '0;
      run_q   <= '0;
      err_q   <= 2'b00;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      crst_q  <= 1'b1;
      run_o_q <= 1'b0;
      hlt_q   <= 1'b0;
      err_o_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      csum_q  <= csum_d;
      run_q   <= run_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      crst_q  <= crst_d;
      run_o_q <= run_o_d;
      hlt_q   <= hlt_d;
      err_o_q <= err_o_d;
    end
  end

  assign in_ready   = rdy_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = crst_q;
  assign running    = run_o_q;
  assign halted     = hlt_q;
  assign error      = err_o_q;
  assign err_code   = err_q;
  assign run_cycles = run_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Random frame bench for imem_boot_loader with a frame-level reference model.
// Define IMEM_BOOT_CHECKSUM_EN to exercise the checksum variant.
module tb_imem_boot_loader;

  localparam int TO_MAIN = 40;
  localparam int TO_T    = 8;
  localparam int MAXW    = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, in_valid, cpu_halt;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, cpu_reset, running, halted, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [1:0]  err_code;
  logic [15:0] run_cycles;

  logic        t_in_ready, t_imem_we, t_cpu_reset, t_running, t_halted, t_error;
  logic [31:0] t_imem_addr, t_imem_wdata;
  logic [1:0]  t_err_code;
  logic [15:0] t_run_cycles;

  imem_boot_loader #(.IMEM_BYTES(1024), .RUN_TIMEOUT(TO_MAIN), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .cpu_halt(cpu_halt),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .running(running), .halted(halted),
    .error(error), .err_code(err_code), .run_cycles(run_cycles)
  );

  imem_boot_loader #(.IMEM_BYTES(1024), .RUN_TIMEOUT(TO_T), .CNT_W(16)) dut_t (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(t_in_ready), .cpu_halt(cpu_halt),
    .imem_we(t_imem_we), .imem_addr(t_imem_addr), .imem_wdata(t_imem_wdata),
    .cpu_reset(t_cpu_reset), .running(t_running), .halted(t_halted),
    .error(t_error), .err_code(t_err_code), .run_cycles(t_run_cycles)
  );

  int n_vec = 0;
  int n_err = 0;
  int waits = 0;
  int dbl_we = 0;
  logic prev_we = 1'b0;
  logic [63:0] wq[$];
  logic [31:0] words[$];

  always @(negedge clk) begin
    if (imem_we) begin
      wq.push_back({imem_addr, imem_wdata});
      if (prev_we) dbl_we++;
    end
    prev_we = imem_we;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 0 ok, 1 length overflow, 2 checksum mismatch
  function automatic int model_err(input int n, input bit badck);
    if (n > MAXW) return 1;
`ifdef IMEM_BOOT_CHECKSUM_EN
    if (badck) return 2;
`endif
    return 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; cpu_halt = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wq.delete();
    dbl_we = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_crst"}, cpu_reset, 1);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_flags"}, {running, halted, error}, 0);
    chk({tag, "_ec"}, err_code, 0);
    chk({tag, "_rc"}, run_cycles, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int smax);
    int bnd;
    bnd = 0;
    in_valid = 1'b0;
    in_data = 8'($urandom);
    repeat ($urandom_range(smax, 0)) @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && bnd < 50) begin
      @(negedge clk);
      bnd++;
      waits++;
    end
    if (bnd == 50) begin
      chk("rdy_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input int smax, input bit badck);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    b = n[7:0];  send_byte(b, smax); cs ^= b;
    b = n[15:8]; send_byte(b, smax); cs ^= b;
    if (n > MAXW) return;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++) begin
        b = words[i][8*j +: 8];
        send_byte(b, smax);
        cs ^= b;
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(badck ? (cs ^ 8'h01) : cs, smax);
`endif
  endtask

  task automatic check_writes(input string tag, input int n);
    chk({tag, "_nwr"}, wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++)
      chk({tag, "_wr"}, wq[i], {32'(i * 4), words[i]});
    chk({tag, "_pulse"}, dbl_we, 0);
  endtask

  task automatic do_frame(input string tag, input int n, input int smax,
                          input int k, input bit badck);
    int e;
    int bnd;
    e = model_err(n, badck);
    wq.delete();
    dbl_we = 0;
    waits = 0;
    cpu_halt = 1'($urandom);
    pulse_start();
    send_frame(n, smax, badck);
    if (e != 0) begin
      chk({tag, "_err"}, error, 1);
      chk({tag, "_ec"}, err_code, 2'(e));
      chk({tag, "_crst"}, cpu_reset, 1);
      check_writes(tag, (e == 1) ? 0 : n);
      return;
    end
    bnd = 0;
    while (!running && bnd < 20) begin
      @(negedge clk);
      bnd++;
    end
    chk({tag, "_run"}, running, 1);
    chk({tag, "_crst0"}, cpu_reset, 0);
    for (int i = 1; i <= k; i++) begin
      cpu_halt = (i == k);
      start = (i == 1);
      @(negedge clk);
    end
    cpu_halt = 1'b0;
    start = 1'b0;
    chk({tag, "_hlt"}, {running, halted, error}, 3'b010);
    chk({tag, "_rc"}, run_cycles, k);
    chk({tag, "_crst1"}, cpu_reset, 1);
    check_writes(tag, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, k;
    bit bad;
    int bnd;

    do_reset();
    check_idle("rst");

    words = '{32'h00500513};
    do_frame("one", 1, 0, 10, 1'b0);

    words = '{32'($urandom), 32'($urandom), 32'($urandom)};
    do_frame("b2b", 3, 0, 5, 1'b0);
    chk("b2b_waits", waits, 0);

    do_frame("ovf", 257, 0, 1, 1'b0);

`ifdef IMEM_BOOT_CHECKSUM_EN
    words = '{32'h00500513};
    do_frame("cks", 1, 0, 1, 1'b1);
`endif

    for (int f = 0; f < 10; f++) begin
      n = ($urandom_range(9, 0) == 0) ? $urandom_range(300, 257) : $urandom_range(6, 0);
      k = $urandom_range(30, 1);
      bad = ($urandom_range(3, 0) == 0);
      words.delete();
      for (int i = 0; i < n && i < MAXW; i++) words.push_back($urandom);
      do_frame("rnd", n, 3, k, bad);
    end

    // timeout: dut_t expires at 8, main dut at 40
    do_reset();
    words = '{32'h00500513};
    pulse_start();
    send_frame(1, 0, 1'b0);
    cpu_halt = 1'b0;
    bnd = 0;
    while (!t_error && bnd < 30) begin @(negedge clk); bnd++; end
    chk("to8_err", t_error, 1);
    chk("to8_ec", t_err_code, 2'b11);
    chk("to8_rc", t_run_cycles, TO_T);
    chk("to8_crst", t_cpu_reset, 1);
    chk("to8_main_run", running, 1);
    bnd = 0;
    while (!error && bnd < 60) begin @(negedge clk); bnd++; end
    chk("to40_err", error, 1);
    chk("to40_ec", err_code, 2'b11);
    chk("to40_rc", run_cycles, TO_MAIN);
    pulse_start();
    chk("restart_ec", err_code, 0);
    chk("restart_t_ec", t_err_code, 0);
    chk("restart_rc", t_run_cycles, 0);
    chk("restart_rdy", in_ready, 1);

    // reset in the middle of a word
    do_reset();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("midrst");
    chk("midrst_nwr", wq.size(), 0);
    words = '{32'hdeadbeef};
    do_frame("after", 1, 1, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Loads a program into the single-cycle CPU's instruction memory from a byte-wide valid/ready stream, then releases the CPU core from reset.
- Watches the core's halt output and records the run length.
- Sits directly upstream of the CPU core, driving its instruction-memory write port and its core reset.
- Instruction-memory clear is tied to system reset only. cpu_reset resets the PC, register file and data memory, but not instruction memory.

Parameters:
- IMEM_BYTES, 1024: instruction memory size in bytes. Maximum loadable word count is IMEM_BYTES/4.
- RUN_TIMEOUT, 65535: maximum RUN cycles before a timeout error.
- CNT_W, 16: width of run_cycles and of the word counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a load from IDLE, HALTED or ERROR
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_ready  out  1  loader accepts a byte
- cpu_halt  in  1  core halt output
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  32  byte address, word aligned
- imem_wdata  out  32  instruction word
- cpu_reset  out  1  core reset, active-high
- running  out  1  state == RUN
- halted  out  1  state == HALTED
- error  out  1  state == ERROR
- err_code  out  2  01 length overflow, 10 checksum mismatch, 11 run timeout
- run_cycles  out  CNT_W  cycles spent in last or current RUN

Behaviour:
- Reset (values apply on the clock edge after reset is sampled high; reset mid-load or mid-run aborts, and writes already made stay in memory):
  - state IDLE, cpu_reset 1, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0.
  - running, halted and error all 0; err_code 00; run_cycles 0; all counters 0.
- Byte transfer: a byte is accepted on an edge where in_valid && in_ready. in_ready is 1 only in LEN_LO, LEN_HI, LOAD and CHK.
- Frame format: word count N (16-bit, low byte first), then N words of 4 bytes each, least significant byte first.
- States and transitions:
  - IDLE/HALTED/ERROR: on start, go to LEN_LO. cpu_reset is 1, run_cycles is cleared, err_code is cleared.
  - LEN_LO: accept byte, store as N[7:0], go to LEN_HI.
  - LEN_HI: accept byte, store as N[15:8].
    - If N > IMEM_BYTES/4: go to ERROR with err_code 01.
    - Else if N == 0: go to CHK (macro defined) or RUN.
    - Else: go to LOAD.
  - LOAD: accept bytes into a 2-bit byte counter and a 32-bit assembly register.
    - On the 4th byte, the next cycle has imem_we=1 for exactly one cycle, imem_addr = word_idx*4, imem_wdata = assembled word.
    - word_idx then increments.
    - in_ready stays 1 during the write cycle, so back-to-back bytes are allowed at one byte per cycle.
    - After the write of word N-1, go to CHK (macro defined) or RUN.
  - RUN: cpu_reset 0 from the first RUN cycle. run_cycles increments each RUN cycle and saturates at its maximum.
    - cpu_halt sampled 1 on any RUN cycle: go to HALTED. run_cycles includes that cycle; cpu_reset returns to 1.
    - run_cycles reaches RUN_TIMEOUT with no halt: go to ERROR with err_code 11.
- Simultaneous events:
  - start is ignored outside IDLE/HALTED/ERROR.
  - cpu_halt is ignored outside RUN.
  - halt and timeout on the same cycle: halt wins.
- Output timing: all outputs are registered. running, halted and error are each asserted in the cycle their state is entered.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - State CHK follows the payload. It accepts one byte, which is compared with the XOR of all header and payload bytes.
  - Equal: go to RUN.
  - Not equal: go to ERROR with err_code 10, and cpu_reset stays 1.
- Undefined: CHK does not exist, RUN follows the last write directly, and err_code 10 never occurs.

Test Plan:
- Load one word: stream 01 00 13 05 50 00, plus checksum byte 47 if the macro is defined. Expect a single imem_we pulse with addr 0x0 and wdata 0x00500513, then cpu_reset 0; hold cpu_halt 0 for 9 cycles, then 1, and expect halted=1, run_cycles=10, cpu_reset=1.
- Back-to-back load of N=3, no stream stalls: expect exactly 3 imem_we pulses at addr 0x0, 0x4, 0x8, with in_ready never dropping.
- Length overflow: send 01 01 (N=257) with IMEM_BYTES=1024. Expect error=1, err_code 01, no imem_we, cpu_reset 1.
- Checksum mismatch (macro defined): send the first frame above with checksum byte 46. Expect error=1, err_code 10, cpu_reset stays 1.
- Timeout with RUN_TIMEOUT=8 and cpu_halt held 0: expect ERROR with err_code 11 and run_cycles=8. A following start pulse restarts the load and clears err_code.
- Reset asserted mid-LOAD after 2 bytes: expect IDLE with all outputs at reset values and no imem_we. A fresh frame then loads correctly from address 0x0.
